muldiv_unit: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M execute unit. It covers all eight M-extension operations with a valid/ready handshake.
- Multiply has a fixed latency. Divide/remainder uses an iterative radix-2 restoring divider, which removes the single-cycle divide from the critical path.
- Sits beside the ALU in the execute stage. The ALU keeps base-ISA ops; M ops are steered here and the pipeline stalls on in_ready/out_valid.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_unit_div_iter.sv | 63 ++++++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension execute unit: funct3 encodings,
// FSM state type and small op-decode helpers.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_BUSY,
    ST_DIV_BUSY,
    ST_DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_div(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic mul_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU);
  endfunction

  function automatic logic mul_b_signed(input logic [2:0] op);
    return op == MD_MULH;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider on unsigned operands. The start edge already
// performs the first quotient step, so XLEN steps finish in XLEN edges.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output logic            o_done
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  logic [XLEN-1:0]  w_rem_in;
  logic [XLEN-1:0]  w_quot_in;
  logic [XLEN-1:0]  w_div_in;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_diff;

  assign w_rem_in  = i_start ? '0 : r_rem;
  assign w_quot_in = i_start ? i_dividend : r_quot;
  assign w_div_in  = i_start ? i_divisor : r_div;
  assign w_shift   = {w_rem_in, w_quot_in[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, w_div_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_abort) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start || (r_active && r_cnt != '0)) begin
      r_div    <= w_div_in;
      r_quot   <= {w_quot_in[XLEN-2:0], ~w_diff[XLEN]};
      r_rem    <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      r_cnt    <= i_start ? CNT_W'(XLEN - 1) : r_cnt - 1'b1;
      r_active <= 1'b1;
    end else begin
      // done is a single-cycle pulse
      r_active <= 1'b0;
    end
  end

  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_done      = r_active && (r_cnt == '0);

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide execute unit with valid/ready handshake.
// state    | meaning
// IDLE     | in_ready=1, waiting for a request
// MUL_BUSY | multiply latency countdown
// DIV_BUSY | iterative divider running
// DONE     | out_valid=1, result held until out_ready
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  srcA,
  input  logic [XLEN-1:0]  srcB,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_sdiv;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_div_special;
  logic             w_div_start;
  logic             w_div_done;
  logic [XLEN-1:0]  w_special_res;
  logic [XLEN-1:0]  w_abs_a;
  logic [XLEN-1:0]  w_abs_b;
  logic [XLEN-1:0]  w_quot;
  logic [XLEN-1:0]  w_rem;
  logic [XLEN-1:0]  w_div_res;
  logic [2:0]       w_mop;
  logic [XLEN-1:0]  w_ma;
  logic [XLEN-1:0]  w_mb;
  logic [2*XLEN-1:0] w_ea;
  logic [2*XLEN-1:0] w_eb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]  w_mul_res;

  assign w_accept      = in_valid && (r_state == ST_IDLE) && !flush;
  assign w_sdiv        = is_signed_div(op);
  assign w_b_zero      = (srcB == '0);
  assign w_ovf         = w_sdiv && (srcA == MOST_NEG) && (srcB == '1);
  assign w_div_special = is_div(op) && (w_b_zero || w_ovf);
  assign w_div_start   = w_accept && is_div(op) && !w_div_special;
  assign w_abs_a       = (w_sdiv && srcA[XLEN-1]) ? -srcA : srcA;
  assign w_abs_b       = (w_sdiv && srcB[XLEN-1]) ? -srcB : srcB;

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = is_rem(op) ? srcA : '1;
    else if (w_ovf) w_special_res = is_rem(op) ? '0 : MOST_NEG;
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_div_start),
    .i_abort     (flush),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_quotient  (w_quot),
    .o_remainder (w_rem),
    .o_done      (w_div_done)
  );

  assign w_div_res = is_rem(r_op) ? (r_neg_r ? -w_rem : w_rem)
                                  : (r_neg_q ? -w_quot : w_quot);

  // Live operands feed the multiplier only when MUL_LAT==1 finishes at accept.
  assign w_mop     = (r_state == ST_IDLE) ? op : r_op;
  assign w_ma      = (r_state == ST_IDLE) ? srcA : r_a;
  assign w_mb      = (r_state == ST_IDLE) ? srcB : r_b;
  assign w_ea      = {{XLEN{mul_a_signed(w_mop) & w_ma[XLEN-1]}}, w_ma};
  assign w_eb      = {{XLEN{mul_b_signed(w_mop) & w_mb[XLEN-1]}}, w_mb};
  assign w_prod    = w_ea * w_eb;
  assign w_mul_res = (w_mop == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_div(op)) w_state_nxt = w_div_special ? ST_DONE : ST_DIV_BUSY;
          else            w_state_nxt = (MUL_LAT == 1) ? ST_DONE : ST_MUL_BUSY;
        end
      end
      ST_MUL_BUSY: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
      ST_DIV_BUSY: if (w_div_done) w_state_nxt = ST_DONE;
      ST_DONE:     if (out_ready) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      r_op    <= op;
      r_a     <= srcA;
      r_b     <= srcB;
      r_tag   <= tag_in;
      r_cnt   <= CNT_W'(MUL_LAT - 1);
      r_neg_q <= w_sdiv && (srcA[XLEN-1] ^ srcB[XLEN-1]);
      r_neg_r <= w_sdiv && srcA[XLEN-1];
      if (w_div_special)                   r_result <= w_special_res;
      else if (!is_div(op) && MUL_LAT == 1) r_result <= w_mul_res;
    end else if (!flush) begin
      case (r_state)
        ST_MUL_BUSY: begin
          if (r_cnt == CNT_W'(1)) r_result <= w_mul_res;
          else                    r_cnt    <= r_cnt - 1'b1;
        end
        ST_DIV_BUSY: if (w_div_done) r_result <= w_div_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign tag_out   = r_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic
// reference model of the RV32M operations and their latencies.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic [4:0]  tag_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_LAT(2), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .tag_in    (tag_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (o)
      MD_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
      MD_MULH:   begin p = sa * sb;                 return p[63:32]; end
      MD_MULHSU: begin p = sa * ub;                 return p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return 2;
    if (b == 0) return 1;
    if ((o == MD_DIV || o == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input int hold);
    logic [31:0] exp_res;
    int          exp_lat;
    int          cyc;
    int          w;
    exp_res = model(o, a, b);
    exp_lat = lat_model(o, a, b);
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before", in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    op        = o;
    srcA      = a;
    srcB      = b;
    tag_in    = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("latency op%0d", o), 64'(cyc), 64'(exp_lat));
    check($sformatf("result op%0d %h/%h", o, a, b), result, exp_res);
    check("tag_out", tag_out, t);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, exp_res);
      check("hold_tag", tag_out, t);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_tag", tag_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(MD_MUL,    32'd7,         32'hFFFF_FFFD, 5'd1, 0);
    do_op(MD_MULH,   32'd7,         32'hFFFF_FFFD, 5'd2, 0);
    do_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    do_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    do_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5, 0);
    do_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,         5'd6, 0);
    do_op(MD_REM,    32'hFFFF_FFF9, 32'd2,         5'd7, 0);
    do_op(MD_DIVU,   32'd100,       32'd7,         5'd8, 0);
    do_op(MD_REMU,   32'd100,       32'd7,         5'd9, 0);
    do_op(MD_DIVU,   32'd5,         32'd0,         5'd10, 0);
    do_op(MD_REM,    32'd5,         32'd0,         5'd11, 0);
    do_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    do_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    do_op(MD_DIV,    32'd1000,      32'hFFFF_FFF9, 5'd14, 10);

    // flush five cycles into a divide
    in_valid = 1'b1; op = MD_DIV; srcA = 32'd1000; srcB = 32'd7; tag_in = 5'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", seen, 0);

    // flush wins over a same-cycle request
    in_valid = 1'b1; flush = 1'b1; op = MD_MUL; srcA = 32'd3; srcB = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", in_ready, 1);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_accept_no_result", seen, 0);

    // asynchronous reset mid-multiply
    in_valid = 1'b1; op = MD_MUL; srcA = 32'd7; srcB = 32'd3; tag_in = 5'd17;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_result", result, 0);
    check("arst_tag", tag_out, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("arst_no_result", seen, 0);
    do_op(MD_DIVU, 32'd9, 32'd3, 5'd21, 0);

    for (int k = 0; k < 60; k++) begin
      do_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
